axi_lite_coeff_loader: RTL and testbench
========================================

// Module: axi_lite_coeff_loader
// PURPOSE
//   AXI4-Lite master that writes a table of FIR coefficients into the filter's AXI4-Lite
//   config slave (s_axi_* of the stream wrapper). A start pulse walks num_taps entries from a
//   local coefficient source and issues one single-beat write per entry. Responses are checked;
//   the block aborts on SLVERR/DECERR or on a response timeout.
// PARAMETERS
//   axi_addr_width  32   AXI4-Lite address width
//   axi_data_width  32   AXI4-Lite data width; must be >= coeff_width
//   coeff_width     16   signed coefficient width
//   num_taps        16   entries written per sequence (>=1)
//   base_addr       0    byte address of coefficient 0
//   addr_stride     4    byte increment between coefficients
//   timeout_cycles  256  max cycles waited per transaction before abort (>=2)
// PORTS
//   clk             in   1                  clock
//   rst_n           in   1                  async active-low reset
//   start           in   1                  pulse: begin load; ignored while busy
//   busy            out  1                  sequence in progress
//   done            out  1                  1-cycle pulse: all num_taps written with OKAY
//   error           out  1                  sticky: aborted; cleared by next accepted start
//   err_idx         out  $clog2(num_taps)+1 index of failing entry (valid when error=1)
//   coeff_idx       out  $clog2(num_taps)+1 index of entry being fetched
//   coeff_data      in   coeff_width        signed coefficient for coeff_idx (combinational)
//   m_axi_awaddr    out  axi_addr_width     write address
//   m_axi_awprot    out  3                  constant 3'b000
//   m_axi_awvalid   out  1                  write address valid
//   m_axi_awready   in   1                  write address ready
//   m_axi_wdata     out  axi_data_width     write data
//   m_axi_wstrb     out  4                  constant all ones
//   m_axi_wvalid    out  1                  write data valid
//   m_axi_wready    in   1                  write data ready
//   m_axi_bresp     in   2                  write response
//   m_axi_bvalid    in   1                  write response valid
//   m_axi_bready    out  1                  write response ready
// BEHAVIOUR
// - Reset: all outputs 0 (awprot=0, wstrb=4'hF constant); state IDLE, idx=0, timer=0.
// - FSM IDLE -> SEND -> RESP -> (SEND | IDLE).
//   IDLE: start=1 -> idx=0, error<=0, busy<=1, latch awaddr=base_addr+idx*addr_stride
//     and wdata=sign-extended coeff_data; assert awvalid and wvalid next cycle (latency 1).
//   SEND: awvalid drops on the cycle after an awready handshake, wvalid likewise, independently.
//     AW-before-W, W-before-AW and simultaneous acceptance are all legal. Once both are
//     accepted -> RESP with bready=1.
//   RESP: on bvalid&bready: bready<=0. bresp==2'b00 and idx==num_taps-1 -> done pulse,
//     busy<=0, IDLE. bresp==2'b00 otherwise -> idx+1, latch next addr/data, SEND.
//     bresp!=2'b00 -> error<=1, err_idx<=idx, busy<=0, IDLE (no done).
// - awaddr/wdata stay stable while the matching valid is high; valids never drop before
//   their handshake, except on timeout.
// - Timer: reset on entering SEND and counts each cycle in SEND/RESP. At timeout_cycles it
//   forces error=1, err_idx=idx, all valids/bready=0, and IDLE. This is the only
//   valid-withdrawal case; it covers a hung slave only.
// - coeff_idx = idx at all times; coeff_data is sampled only when addr/data are latched.
// - start while busy: ignored. start in the same cycle as done/abort return: ignored
//   (IDLE is entered the next cycle).
// - Address arithmetic is modulo 2^axi_addr_width (wraps silently).
// - Reset asserted mid-sequence: all outputs return to 0 asynchronously, with no done/error.
// TESTING
// - num_taps=4, coeffs {1,-2,3,-4}, zero-wait slave -> awaddr 0,4,8,12; wdata 1,FFFFFFFE,
//   3,FFFFFFFC; done pulse once.
// - awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds
//   with stable addr, then RESP.
// - bresp=2'b10 on idx 2 -> error=1, err_idx=2, no done, no 4th write; next start clears error.
// - Slave never asserts bvalid, timeout_cycles=8 -> error=1, err_idx=0 at cycle 8, bready=0.
// - rst_n low during idx 1 RESP -> busy/valids/bready=0 immediately; restart writes from idx 0.
// - start pulsed again while busy -> ignored; exactly 4 writes and 1 done observed.

Source files
------------

// File: rtl/axi_lite_coeff_loader.sv
// AXI4-Lite write master that streams a coefficient table into a config slave,
// one single-beat write per entry, aborting on an error response or a hung slave.
module axi_lite_coeff_loader #(
  parameter int                        axi_addr_width = 32,
  parameter int                        axi_data_width = 32,
  parameter int                        coeff_width    = 16,
  parameter int                        num_taps       = 16,
  parameter logic [axi_addr_width-1:0] base_addr      = '0,
  parameter int unsigned               addr_stride    = 4,
  parameter int                        timeout_cycles = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [$clog2(num_taps):0]       err_idx,
  output logic [$clog2(num_taps):0]       coeff_idx,
  input  logic [coeff_width-1:0]          coeff_data,
  output logic [axi_addr_width-1:0]       m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [axi_data_width-1:0]       m_axi_wdata,
  output logic [3:0]                      m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int idx_width   = $clog2(num_taps) + 1;
  localparam int timer_width = $clog2(timeout_cycles) + 1;
  localparam logic [idx_width-1:0]   last_idx   = idx_width'(num_taps - 1);
  localparam logic [timer_width-1:0] timer_last = timer_width'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t                       state_reg, state_next;
  logic [idx_width-1:0]         idx_reg, idx_next;
  logic [timer_width-1:0]       timer_reg, timer_next;
  logic [axi_addr_width-1:0]    awaddr_reg, awaddr_next;
  logic [axi_data_width-1:0]    wdata_reg, wdata_next;
  logic                         awvalid_reg, awvalid_next;
  logic                         wvalid_reg, wvalid_next;
  logic                         bready_reg, bready_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         error_reg, error_next;
  logic [idx_width-1:0]         err_idx_reg, err_idx_next;
  logic                         load_pending_reg, load_pending_next;
  logic                         load;
  logic                         abort;
  logic [axi_data_width-1:0]    coeff_ext;
  logic [axi_addr_width-1:0]    idx_addr;

  for (genvar gi = 0; gi < axi_data_width; gi++) begin : g_sext
    if (gi < coeff_width) begin : g_bit
      assign coeff_ext[gi] = coeff_data[gi];
    end else begin : g_sign
      assign coeff_ext[gi] = coeff_data[coeff_width-1];
    end
  end

  assign idx_addr = base_addr + axi_addr_width'(addr_stride) * axi_addr_width'(idx_reg);

  // After each OKAY the index advances first and the new entry is latched one
  // cycle later, so coeff_data always corresponds to the visible coeff_idx.
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    timer_next        = timer_reg;
    awaddr_next       = awaddr_reg;
    wdata_next        = wdata_reg;
    awvalid_next      = awvalid_reg;
    wvalid_next       = wvalid_reg;
    bready_next       = bready_reg;
    busy_next         = busy_reg;
    done_next         = 1'b0;
    error_next        = error_reg;
    err_idx_next      = err_idx_reg;
    load_pending_next = load_pending_reg;
    load              = 1'b0;
    abort             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          error_next = 1'b0;
          busy_next  = 1'b1;
          timer_next = '0;
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        timer_next = timer_reg + timer_width'(1);
        if (load_pending_reg) begin
          load_pending_next = 1'b0;
          load              = 1'b1;
        end else begin
          awvalid_next = awvalid_reg & ~m_axi_awready;
          wvalid_next  = wvalid_reg & ~m_axi_wready;
          if (!awvalid_next && !wvalid_next) begin
            bready_next = 1'b1;
            state_next  = RESP;
          end else if (timer_reg == timer_last) begin
            abort = 1'b1;
          end
        end
      end
      RESP: begin
        timer_next = timer_reg + timer_width'(1);
        if (m_axi_bvalid && bready_reg) begin
          bready_next = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            error_next   = 1'b1;
            err_idx_next = idx_reg;
            busy_next    = 1'b0;
            idx_next     = '0;
            state_next   = IDLE;
          end else if (idx_reg == last_idx) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next          = idx_reg + idx_width'(1);
            timer_next        = '0;
            load_pending_next = 1'b1;
            state_next        = SEND;
          end
        end else if (timer_reg == timer_last) begin
          abort = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      awaddr_next  = idx_addr;
      wdata_next   = coeff_ext;
      awvalid_next = 1'b1;
      wvalid_next  = 1'b1;
    end

    // Hung slave: withdraw everything and report the entry that stalled.
    if (abort) begin
      error_next        = 1'b1;
      err_idx_next      = idx_reg;
      awvalid_next      = 1'b0;
      wvalid_next       = 1'b0;
      bready_next       = 1'b0;
      busy_next         = 1'b0;
      load_pending_next = 1'b0;
      idx_next          = '0;
      state_next        = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      timer_reg        <= '0;
      awaddr_reg       <= '0;
      wdata_reg        <= '0;
      awvalid_reg      <= 1'b0;
      wvalid_reg       <= 1'b0;
      bready_reg       <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      err_idx_reg      <= '0;
      load_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      timer_reg        <= timer_next;
      awaddr_reg       <= awaddr_next;
      wdata_reg        <= wdata_next;
      awvalid_reg      <= awvalid_next;
      wvalid_reg       <= wvalid_next;
      bready_reg       <= bready_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      error_reg        <= error_next;
      err_idx_reg      <= err_idx_next;
      load_pending_reg <= load_pending_next;
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign err_idx       = err_idx_reg;
  assign coeff_idx     = idx_reg;
  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;

endmodule

// File: tb/tb_axi_lite_coeff_loader.sv
// Bench for axi_lite_coeff_loader: a randomized-latency AXI4-Lite slave records
// every write and each sequence is scored against the expected table walk.
module tb_axi_lite_coeff_loader;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [2:0]  err_idx, coeff_idx;
  logic [15:0] coeff_data;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  bresp;

  logic signed [15:0] coeffs [NT];

  int n_checks = 0;
  int n_errors = 0;
  int seq_no   = 0;

  // slave configuration: fixed delays (-1 = random 0..2), error position, hang
  int fx_aw, fx_w, fx_b;
  int err_at;
  bit hang;

  // slave state
  int aw_cnt, w_cnt, b_cnt, aw_rnd, w_rnd, b_rnd, b_done, done_cnt;
  bit b_fired, aw_hold, w_hold;
  logic [31:0] held_addr, held_data;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  always #5 clk = ~clk;

  assign coeff_data = (coeff_idx < 3'(NT)) ? coeffs[coeff_idx[1:0]] : 16'h0000;

  axi_lite_coeff_loader #(
    .num_taps      (NT),
    .timeout_cycles(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_idx      (err_idx),
    .coeff_idx    (coeff_idx),
    .coeff_data   (coeff_data),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int fx, input int rnd);
    return (fx >= 0) ? fx : rnd;
  endfunction

  // Slave: everything decided on the falling edge, handshakes land on the next rising edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_fired = 1'b0;
      aw_hold = 1'b0; w_hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (aw_hold) begin
        check_eq("awvalid_held", 64'(awvalid), 64'd1);
        check_eq("awaddr_stable", 64'(awaddr), 64'(held_addr));
      end
      if (w_hold) begin
        check_eq("wvalid_held", 64'(wvalid), 64'd1);
        check_eq("wdata_stable", 64'(wdata), 64'(held_data));
      end
      if (b_fired) begin
        bvalid = 1'b0;
        b_fired = 1'b0;
      end
      if (!bvalid && !hang && aw_q.size() > b_done && w_q.size() > b_done) begin
        if (b_cnt >= eff(fx_b, b_rnd)) begin
          bvalid = 1'b1;
          bresp  = (b_done == err_at) ? 2'b10 : 2'b00;
          b_cnt  = 0;
        end else b_cnt++;
      end
      if (bvalid && bready) begin
        b_fired = 1'b1;
        b_done++;
        b_rnd = $urandom_range(0, 2);
      end
      awready = 1'b0;
      if (awvalid) begin
        if (aw_cnt >= eff(fx_aw, aw_rnd)) begin
          awready = 1'b1;
          aw_q.push_back(awaddr);
          aw_cnt = 0;
          aw_rnd = $urandom_range(0, 2);
        end else aw_cnt++;
      end
      aw_hold = awvalid && !awready;
      held_addr = awaddr;
      wready = 1'b0;
      if (wvalid) begin
        if (w_cnt >= eff(fx_w, w_rnd)) begin
          wready = 1'b1;
          w_q.push_back(wdata);
          w_cnt = 0;
          w_rnd = $urandom_range(0, 2);
        end else w_cnt++;
      end
      w_hold = wvalid && !wready;
      held_data = wdata;
    end
  end

  task automatic clear_slave();
    aw_q.delete();
    w_q.delete();
    b_done = 0; done_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
  endtask

  task automatic randomize_coeffs();
    for (int i = 0; i < NT; i++) coeffs[i] = 16'($urandom);
  endtask

  // One load sequence; expected result derived from the table and the slave plan.
  task automatic run_seq(input int e_at, input bit hang_mode, input bit hold_start, input bit probe_aw);
    int exp_n;
    bit finished;
    bit ok;
    logic [31:0] exp_a, exp_d;
    clear_slave();
    err_at = e_at;
    hang   = hang_mode;
    start  = 1'b1;
    finished = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk); #1;
      if (!hold_start) start = 1'b0;
      if (k == 1) begin
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("error_cleared_on_start", 64'(error), 64'd0);
        check_eq("valids_latency1", 64'({awvalid, wvalid}), 64'b11);
      end
      if (probe_aw && k == 2)
        check_eq("wvalid_drop_awvalid_hold", 64'({awvalid, wvalid}), 64'b10);
      if (hang_mode && k == 8)
        check_eq("before_timeout_busy_err", 64'({busy, error}), 64'b10);
      if (hang_mode && k == 9)
        check_eq("timeout_abort_state", 64'({busy, error, bready, awvalid, wvalid, err_idx}),
                 64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_eq("sequence_terminates", 64'(finished), 64'd1);

    ok    = (e_at < 0) && !hang_mode;
    exp_n = hang_mode ? 1 : (e_at < 0 ? NT : e_at + 1);
    check_eq("aw_write_count", 64'(aw_q.size()), 64'(exp_n));
    check_eq("w_write_count", 64'(w_q.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < aw_q.size() && i < w_q.size(); i++) begin
      exp_a = 32'(i * 4);
      exp_d = 32'(int'(coeffs[i]));
      check_eq("awaddr", 64'(aw_q[i]), 64'(exp_a));
      check_eq("wdata", 64'(w_q[i]), 64'(exp_d));
    end
    check_eq("done_pulses", 64'(done_cnt), ok ? 64'd1 : 64'd0);
    check_eq("error_flag", 64'(error), ok ? 64'd0 : 64'd1);
    if (!ok) check_eq("err_idx", 64'(err_idx), hang_mode ? 64'd0 : 64'(e_at));

    repeat (3) @(negedge clk);
    #1;
    check_eq("idle_after_seq", 64'(busy), 64'd0);
    check_eq("no_extra_writes", 64'(aw_q.size()), 64'(exp_n));
    $display("seq %0d: writes=%0d done=%0d error=%0d err_idx=%0d",
             seq_no, aw_q.size(), done_cnt, error, err_idx);
    seq_no++;
  endtask

  task automatic reset_mid_sequence();
    bit found;
    clear_slave();
    err_at = -1; hang = 1'b0; fx_b = 3;
    start = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (coeff_idx == 3'd1 && bready) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reached_idx1_resp", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_ctrl", 64'({busy, done, error, awvalid, wvalid, bready, coeff_idx}), 64'd0);
    check_eq("async_reset_addr_data", 64'({awaddr, wdata}), 64'd0);
    $display("seq %0d: reset asserted during idx 1 response", seq_no);
    seq_no++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fx_b = -1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    fx_aw = 0; fx_w = 0; fx_b = 0; err_at = -1; hang = 1'b0;
    aw_rnd = 0; w_rnd = 0; b_rnd = 0;
    clear_slave();
    coeffs[0] = 16'sd1; coeffs[1] = -16'sd2; coeffs[2] = 16'sd3; coeffs[3] = -16'sd4;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_ctrl", 64'({busy, done, error, awvalid, wvalid, bready, err_idx, coeff_idx}), 64'd0);
    check_eq("reset_addr_data", 64'({awaddr, wdata}), 64'd0);
    check_eq("reset_prot_strb", 64'({awprot, wstrb}), 64'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait slave with the reference table
    run_seq(-1, 1'b0, 1'b0, 1'b0);

    // AW accepted late, W immediately
    fx_aw = 3; fx_w = 0; fx_b = 0;
    run_seq(-1, 1'b0, 1'b0, 1'b1);

    // SLVERR on entry 2, then a clean sequence clears the error
    fx_aw = -1; fx_w = -1; fx_b = -1;
    randomize_coeffs();
    run_seq(2, 1'b0, 1'b0, 1'b0);
    randomize_coeffs();
    run_seq(-1, 1'b0, 1'b0, 1'b0);

    // Slave never responds
    fx_aw = 0; fx_w = 0; fx_b = 0;
    run_seq(-1, 1'b1, 1'b0, 1'b0);

    // Reset during the second response, then a full restart from entry 0
    fx_aw = -1; fx_w = -1;
    reset_mid_sequence();
    randomize_coeffs();
    run_seq(-1, 1'b0, 1'b0, 1'b0);

    // start held high through the whole sequence including the done cycle
    randomize_coeffs();
    run_seq(-1, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      randomize_coeffs();
      run_seq(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NT - 1)) : -1, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
